sqrt_iterative: RTL and testbench

SQRT_ITERATIVE -- requirements
Module: sqrt_iterative

---
 rtl/sqrt_iterative.sv | 171 +++++++++++++++++
 tb/tb_sqrt_iterative.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iterative.sv
// ---------------------------------------------------------------------------
// sqrt_iterative
//   Multi-cycle integer square root of a signed radicand using the
//   digit-by-digit restoring method, two radicand bits per clock.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE. out_valid stays high, with root,
//   rem and err frozen, until the edge where out_ready is also high.
//
//   Parameters
//     IN_WIDTH   radicand width (even, >= 4)
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   radicand offered
//     in_ready   block accepts a radicand (IDLE only)
//     a          radicand, signed two's complement
//     out_valid  result held
//     out_ready  consumer accepts the result
//     root       unsigned square root (floor, or rounded, see below)
//     rem        floor remainder a - floor_root^2
//     err        negative radicand flag
//     fsm_state  debug view of the FSM state (0 IDLE, 1 CALC, 2 DONE)
//
//   Build option
//     SQRT_ROUND_EN  when defined, root is rounded to nearest
//                    (floor_root+1 when rem > floor_root); rem stays the
//                    floor remainder. Undefined: root is the floor.
// ---------------------------------------------------------------------------
module sqrt_iterative #(
    parameter int IN_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_WIDTH/2-1:0] root,
    output logic [IN_WIDTH/2:0]   rem,
    output logic                  err,
    output logic [1:0]            fsm_state
);

    localparam int HALF  = IN_WIDTH / 2;
    localparam int REM_W = HALF + 2;
    localparam int CNT_W = $clog2(HALF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [IN_WIDTH-1:0] x;         // radicand, shifted left two bits per step
    logic [REM_W-1:0]    rem_acc;
    logic [HALF-1:0]     root_acc;
    logic [CNT_W-1:0]    cnt;

    logic                last_step;
    logic                handshake;
    logic [REM_W-1:0]    shifted;
    logic [REM_W-1:0]    subtrahend;
    logic [REM_W:0]      trial;
    logic [REM_W-1:0]    step_rem;
    logic [HALF-1:0]     step_root;
    logic [HALF:0]       rem_final;
    logic [HALF-1:0]     root_final;

    assign fsm_state = state;
    assign last_step = (cnt == CNT_W'(HALF - 1));
    assign handshake = out_valid && out_ready;

    // One restoring step. The remainder never exceeds twice the partial
    // root, so dropping the top two bits of rem_acc on the shift loses nothing.
    always_comb begin
        shifted    = {rem_acc[REM_W-3:0], x[IN_WIDTH-1 -: 2]};
        subtrahend = {root_acc, 2'b01};
        trial      = {1'b0, shifted} - {1'b0, subtrahend};
        if (trial[REM_W]) begin
            step_rem  = shifted;
            step_root = {root_acc[HALF-2:0], 1'b0};
        end else begin
            step_rem  = trial[REM_W-1:0];
            step_root = {root_acc[HALF-2:0], 1'b1};
        end
        rem_final = step_rem[HALF:0];
`ifdef SQRT_ROUND_EN
        // floor_root+1 cannot overflow: a signed radicand keeps the root
        // well below 2^HALF - 1.
        root_final = step_root + HALF'(rem_final > {1'b0, step_root});
`else
        root_final = step_root;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) next_state = a[IN_WIDTH-1] ? DONE : CALC;
            end
            CALC: begin
                if (last_step) next_state = DONE;
            end
            DONE: begin
                if (handshake) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs. out_valid follows DONE by one cycle,
    // which gives the N+HALF+1 / N+1 result timing and keeps in_ready low in
    // the cycle of the output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            root      <= '0;
            rem       <= '0;
            err       <= 1'b0;
            x         <= '0;
            rem_acc   <= '0;
            root_acc  <= '0;
            cnt       <= '0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (state == DONE) && !handshake;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= a;
                        rem_acc  <= '0;
                        root_acc <= '0;
                        cnt      <= '0;
                        if (a[IN_WIDTH-1]) begin
                            root <= '0;
                            rem  <= '0;
                            err  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    x        <= {x[IN_WIDTH-3:0], 2'b00};
                    rem_acc  <= step_rem;
                    root_acc <= step_root;
                    cnt      <= cnt + 1'b1;
                    if (last_step) begin
                        root <= root_final;
                        rem  <= rem_final;
                        err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iterative.sv
module tb_sqrt_iterative;

  localparam int W    = 32;
  localparam int HALF = W / 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic            out_valid;
  logic            out_ready;
  logic [HALF-1:0] root;
  logic [HALF:0]   rem;
  logic            err;
  logic [1:0]      fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W+1:0] exp_q[$];   // {err, root, rem}
  longint       lat_q[$];   // expected time of out_valid rise

  sqrt_iterative #(.IN_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [W+1:0] model(input logic [W-1:0] v);
    longint r;
    longint rm;
    logic [HALF-1:0] r_out;
    if (v[W-1]) return {1'b1, {HALF{1'b0}}, {(HALF+1){1'b0}}};
    r  = isqrt(longint'(v));
    rm = longint'(v) - r * r;
`ifdef SQRT_ROUND_EN
    r_out = (rm > r) ? HALF'(r + 1) : HALF'(r);
`else
    r_out = HALF'(r);
`endif
    return {1'b0, r_out, (HALF+1)'(rm)};
  endfunction

  // driver: call at a negedge (or just after a posedge)
  task automatic send(input logic [W-1:0] v);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    a        = v;
    @(posedge clk);
    exp_q.push_back(model(v));
    lat_q.push_back(longint'($time) + (v[W-1] ? 10 : (HALF + 1) * 10));
    #1;
    in_valid = 1'b0;
    a        = $urandom;   // must not be sampled outside IDLE
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard / monitor
  logic         prev_stall;
  logic [W+1:0] last_out;
  logic [W+1:0] cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {err, root, rem};
      if (out_valid) begin
        check("in_ready_low", in_ready, 0);
        if (!prev_stall) begin
          if (lat_q.size() == 0) check("unexpected_valid", 1, 0);
          else check("latency", longint'($time) - 5, lat_q.pop_front());
        end else begin
          check("stable", cur, last_out);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 1, 0);
          else check("result", cur, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      last_out   = cur;
    end
  end

  initial begin
    logic [W-1:0] v;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_root", root, 0);
    check("rst_rem", rem, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;

    // first acceptance on the first edge after release
    send(32'd0);
    send(32'd99);
    send(32'd2147483647);
    send(-32'sd5);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    send(32'd15);
    send(32'hFFFF_FFFF);
    send(32'h8000_0000);
    send(32'd65535);
    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      send(v);
    end
    wait_drain();

    // stall with a=144
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'd144);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_root", root, 12);
      check("stall_state", fsm_state, 2);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_state", fsm_state, 0);
    wait_drain();

    // reset during CALC
    send(32'd1000);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_root", root, 0);
    check("mid_rst_rem", rem, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_state", fsm_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_valid_after_rst", out_valid, 0);
    end
    send(32'd16);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
